if_id_skid_buffer: RTL and testbench
====================================

Name: if_id_skid_buffer

Overview:
- Registered boundary between the instruction-fetch stage and the decode stage.
- Accepts a {pc, insn} pair from fetch on a valid/ready handshake and presents it to decode one cycle later.
- Holds up to two entries so a decode stall never forces a combinational path from decode's ready back into the PC/instruction memory.
- Supports a flush from branch/jump resolution that turns everything in flight into bubbles.

Parameters:
- ADDR_W, 32, width of instruction address path
- INSN_W, 32, width of instruction word
- NOP_INSN, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven when no valid entry

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- if_valid  in  1  fetch presents a valid {if_pc, if_insn}
- if_pc  in  ADDR_W  fetched instruction address
- if_insn  in  INSN_W  fetched instruction word
- if_ready  out  1  buffer can accept this cycle (= state != FULL; depends on registered state only)
- flush  in  1  discard all held and incoming entries
- id_ready  in  1  decode consumes head entry this cycle (low = stall)
- id_valid  out  1  head entry valid
- id_pc  out  ADDR_W  head entry address
- id_pc_plus4  out  ADDR_W  id_pc + 4, modulo 2^ADDR_W
- id_insn  out  INSN_W  head entry instruction; NOP_INSN when id_valid=0

Behaviour:
- Reset (rst=0 at a clk edge): state=EMPTY, id_valid=0, id_pc=0, id_pc_plus4=4, id_insn=NOP_INSN, skid contents cleared. if_ready reads 1 in the first cycle after reset release.
- push = if_valid & if_ready; pop = id_valid & id_ready.
- States: EMPTY (0 entries), ONE (head only), FULL (head + skid).
- EMPTY:
  - push -> ONE; head loads the input.
  - Latency is 1 cycle: data pushed at edge N is visible on id_* after edge N.
- ONE:
  - push & pop -> ONE; head loads the input.
  - push & !pop -> FULL; skid loads the input.
  - !push & pop -> EMPTY.
  - !push & !pop -> ONE, hold.
- FULL:
  - if_ready=0, so push is impossible.
  - pop -> ONE; head loads from skid.
  - !pop -> FULL, hold.
- Ordering is strict FIFO. The skid never bypasses the head.
- Flush:
  - At the edge where flush=1, the next state is EMPTY and id_valid=0.
  - The incoming push in that same cycle is discarded.
  - Flush has priority over push, pop and stall. A pop in the flush cycle still counts as consumed by decode.
- id_insn is forced to NOP_INSN whenever id_valid=0. id_pc and id_pc_plus4 hold their last value when invalid (don't-care for decode, but deterministic).
- id_pc_plus4 wraps: id_pc=32'hFFFF_FFFC gives 32'h0000_0000.
- Reset mid-operation (any state, any flush/push) behaves identically to the reset values above.
- No combinational path from id_ready or flush to if_ready.

Decomposition:
- Shared Types package:
  - instructionAddrPath / instruction widths (ADDR_W, INSN_W)
  - NOP_INSN constant
  - a packed fetch-packet struct {pc, insn}
  - buffer state enum {EMPTY, ONE, FULL}
- One natural sub-module: if_id_entry_reg. A single {valid, pc, insn} register with load/clear enables, instantiated twice (head, skid). The parent holds the FSM and the muxing.

Test Plan:
- Reset: hold rst=0 for 2 cycles with if_valid=1 -> id_valid=0, id_insn=32'h00000013, id_pc_plus4=4, if_ready=1 after release.
- Streaming: id_ready=1; push pc=0x100/insn=0x00500093, then pc=0x104/insn=0x00A00113 on back-to-back cycles -> same pairs on id_* one cycle later each, id_pc_plus4=0x104/0x108, no bubbles.
- Stall fill: id_ready=0; push 0x200, 0x204 -> if_ready=0 after second push. Then raise id_ready -> 0x200 then 0x204 delivered in order, if_ready=1 after the first pop.
- Flush in FULL with simultaneous if_valid=1 (pc=0x300) -> next cycle id_valid=0, id_insn=NOP, state EMPTY. 0x300 never appears on id_*.
- Wrap: push pc=32'hFFFF_FFFC -> id_pc_plus4=32'h0000_0000.
- Reset while FULL -> all outputs return to reset values on the next edge. Entries held before reset are never delivered afterwards.

Source files
------------

// File: rtl/if_id_skid_buffer_pkg.sv
// Shared types for the IF/ID pipeline boundary.
package if_id_skid_buffer_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INSN_W = 32;

    // addi x0, x0, 0 -- the canonical bubble
    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INSN_W-1:0] insn;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/if_id_entry_reg.sv
// One {valid, pc, insn} slot with load and clear enables; clear wins over load.
module if_id_entry_reg #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSN_W   = 32,
    parameter logic [INSN_W-1:0]  NOP_INSN = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [INSN_W-1:0] i_insn,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_pc,
    output logic [INSN_W-1:0] o_insn
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic [INSN_W-1:0] r_insn;

    // Slot storage; clear only drops valid so pc/insn stay deterministic
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_insn  <= NOP_INSN;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_insn  <= i_insn;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_insn  = r_insn;

endmodule

// File: rtl/if_id_skid_buffer.sv
// Two-entry registered IF->ID boundary: head feeds decode, skid absorbs one
// extra fetch while decode stalls so if_ready depends only on local state.
module if_id_skid_buffer
    import if_id_skid_buffer_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSN_W   = 32,
    parameter logic [INSN_W-1:0]  NOP_INSN = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INSN_W-1:0] if_insn,
    output logic              if_ready,
    input  logic              flush,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_plus4,
    output logic [INSN_W-1:0] id_insn
);

    buf_state_t        r_state;

    logic              w_push;
    logic              w_pop;
    logic              w_head_load;
    logic              w_head_clear;
    logic [ADDR_W-1:0] w_head_pc_d;
    logic [INSN_W-1:0] w_head_insn_d;
    logic              w_skid_load;
    logic              w_skid_clear;

    logic              w_head_valid;
    logic [ADDR_W-1:0] w_head_pc;
    logic [INSN_W-1:0] w_head_insn;
    logic              w_skid_valid;
    logic [ADDR_W-1:0] w_skid_pc;
    logic [INSN_W-1:0] w_skid_insn;

    assign if_ready = (r_state != ST_FULL);
    assign w_push   = if_valid & if_ready;
    assign w_pop    = w_head_valid & id_ready;

    // Slot enables and head source select derived from state and handshakes
    always_comb begin
        w_head_load   = 1'b0;
        w_head_clear  = flush;
        w_head_pc_d   = if_pc;
        w_head_insn_d = if_insn;
        w_skid_load   = 1'b0;
        w_skid_clear  = flush;
        unique case (r_state)
            ST_EMPTY: begin
                w_head_load = w_push;
            end
            ST_ONE: begin
                w_head_load = w_push & w_pop;
                w_skid_load = w_push & ~w_pop;
                if (!w_push && w_pop) w_head_clear = 1'b1;
            end
            ST_FULL: begin
                w_head_load   = w_pop;
                w_head_pc_d   = w_skid_pc;
                w_head_insn_d = w_skid_insn;
                if (w_pop) w_skid_clear = 1'b1;
            end
            default: begin
                w_head_clear = 1'b1;
                w_skid_clear = 1'b1;
            end
        endcase
    end

    // Occupancy FSM; flush drains everything regardless of handshakes
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else if (flush) begin
            r_state <= ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: if (w_push) r_state <= ST_ONE;
                ST_ONE: begin
                    if (w_push && !w_pop)      r_state <= ST_FULL;
                    else if (!w_push && w_pop) r_state <= ST_EMPTY;
                end
                ST_FULL:  if (w_pop) r_state <= ST_ONE;
                default:  r_state <= ST_EMPTY;
            endcase
        end
    end

    if_id_entry_reg #(
        .ADDR_W   (ADDR_W),
        .INSN_W   (INSN_W),
        .NOP_INSN (NOP_INSN)
    ) u_head (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_head_load),
        .i_clear (w_head_clear),
        .i_pc    (w_head_pc_d),
        .i_insn  (w_head_insn_d),
        .o_valid (w_head_valid),
        .o_pc    (w_head_pc),
        .o_insn  (w_head_insn)
    );

    if_id_entry_reg #(
        .ADDR_W   (ADDR_W),
        .INSN_W   (INSN_W),
        .NOP_INSN (NOP_INSN)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (if_pc),
        .i_insn  (if_insn),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_insn  (w_skid_insn)
    );

    assign id_valid    = w_head_valid;
    assign id_pc       = w_head_pc;
    assign id_pc_plus4 = w_head_pc + ADDR_W'(4);
    assign id_insn     = w_head_valid ? w_head_insn : NOP_INSN;

    // Skid occupancy is implied by r_state; its valid bit is kept for symmetry
    logic w_unused;
    assign w_unused = w_skid_valid;

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench for the IF/ID skid buffer with hand-computed expectations.
module tb_if_id_skid_buffer;
    import if_id_skid_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic        if_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_insn;

    int unsigned total = 0;
    int unsigned bad   = 0;

    if_id_skid_buffer #(
        .ADDR_W   (32),
        .INSN_W   (32),
        .NOP_INSN (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .if_ready    (if_ready),
        .flush       (flush),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_insn     (id_insn)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input fetch_pkt_t p);
        if_valid = v;
        if_pc    = p.pc;
        if_insn  = p.insn;
    endtask

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b1;
        drive(1'b1, '{pc: 32'h900, insn: 32'hDEAD_BEEF});

        // reset held two cycles with fetch asserting valid
        tick(); tick();
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_insn",  id_insn, 32'h0000_0013);
        chk("rst_pc",    id_pc, 32'h0);
        chk("rst_pc4",   id_pc_plus4, 32'h4);
        rst = 1'b1;
        drive(1'b0, '{pc: 32'h0, insn: 32'h0});
        chk("rst_ready", {31'd0, if_ready}, 32'd1);
        tick();
        chk("rst_ready2", {31'd0, if_ready}, 32'd1);
        chk("rst_valid2", {31'd0, id_valid}, 32'd0);

        // streaming, back-to-back
        id_ready = 1'b1;
        drive(1'b1, '{pc: 32'h100, insn: 32'h0050_0093});
        tick();
        chk("s1_valid", {31'd0, id_valid}, 32'd1);
        chk("s1_pc",    id_pc, 32'h100);
        chk("s1_insn",  id_insn, 32'h0050_0093);
        chk("s1_pc4",   id_pc_plus4, 32'h104);
        drive(1'b1, '{pc: 32'h104, insn: 32'h00A0_0113});
        tick();
        chk("s2_valid", {31'd0, id_valid}, 32'd1);
        chk("s2_pc",    id_pc, 32'h104);
        chk("s2_insn",  id_insn, 32'h00A0_0113);
        chk("s2_pc4",   id_pc_plus4, 32'h108);
        drive(1'b0, '{pc: 32'h0, insn: 32'h0});
        tick();
        chk("s3_valid", {31'd0, id_valid}, 32'd0);
        chk("s3_insn",  id_insn, 32'h0000_0013);
        chk("s3_pc",    id_pc, 32'h104);

        // stall fill then drain in order
        id_ready = 1'b0;
        drive(1'b1, '{pc: 32'h200, insn: 32'h0000_1111});
        tick();
        chk("f1_pc",    id_pc, 32'h200);
        chk("f1_ready", {31'd0, if_ready}, 32'd1);
        drive(1'b1, '{pc: 32'h204, insn: 32'h0000_2222});
        tick();
        chk("f2_ready", {31'd0, if_ready}, 32'd0);
        chk("f2_pc",    id_pc, 32'h200);
        chk("f2_insn",  id_insn, 32'h0000_1111);
        drive(1'b1, '{pc: 32'h208, insn: 32'h0000_3333});
        tick();
        chk("f3_hold_pc", id_pc, 32'h200);
        chk("f3_ready",   {31'd0, if_ready}, 32'd0);
        id_ready = 1'b1;
        tick();
        chk("d1_pc",    id_pc, 32'h204);
        chk("d1_insn",  id_insn, 32'h0000_2222);
        chk("d1_valid", {31'd0, id_valid}, 32'd1);
        chk("d1_ready", {31'd0, if_ready}, 32'd1);
        drive(1'b0, '{pc: 32'h0, insn: 32'h0});
        tick();
        chk("d2_valid", {31'd0, id_valid}, 32'd0);

        // flush while FULL with a simultaneous push
        id_ready = 1'b0;
        drive(1'b1, '{pc: 32'h280, insn: 32'h0000_4444});
        tick();
        drive(1'b1, '{pc: 32'h284, insn: 32'h0000_5555});
        tick();
        chk("fl_full", {31'd0, if_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, '{pc: 32'h300, insn: 32'h0000_6666});
        tick();
        chk("fl_valid", {31'd0, id_valid}, 32'd0);
        chk("fl_insn",  id_insn, 32'h0000_0013);
        chk("fl_ready", {31'd0, if_ready}, 32'd1);
        chk("fl_pc",    id_pc, 32'h280);
        flush    = 1'b0;
        id_ready = 1'b1;
        drive(1'b0, '{pc: 32'h0, insn: 32'h0});
        tick();
        chk("fl_after_valid", {31'd0, id_valid}, 32'd0);
        chk("fl_after_pc",    id_pc, 32'h280);

        // pc+4 wraps around the address space
        drive(1'b1, '{pc: 32'hFFFF_FFFC, insn: 32'h0000_7777});
        tick();
        chk("wrap_pc",  id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc_plus4, 32'h0000_0000);
        drive(1'b0, '{pc: 32'h0, insn: 32'h0});
        tick();

        // reset while FULL
        id_ready = 1'b0;
        drive(1'b1, '{pc: 32'h400, insn: 32'h0000_8888});
        tick();
        drive(1'b1, '{pc: 32'h404, insn: 32'h0000_9999});
        tick();
        chk("rf_full", {31'd0, if_ready}, 32'd0);
        rst = 1'b0;
        drive(1'b1, '{pc: 32'h500, insn: 32'h0000_AAAA});
        tick();
        chk("rf_valid", {31'd0, id_valid}, 32'd0);
        chk("rf_pc",    id_pc, 32'h0);
        chk("rf_pc4",   id_pc_plus4, 32'h4);
        chk("rf_insn",  id_insn, 32'h0000_0013);
        chk("rf_ready", {31'd0, if_ready}, 32'd1);
        rst      = 1'b1;
        id_ready = 1'b1;
        drive(1'b0, '{pc: 32'h0, insn: 32'h0});
        tick();
        chk("rf_after1", {31'd0, id_valid}, 32'd0);
        tick();
        chk("rf_after2", {31'd0, id_valid}, 32'd0);
        chk("rf_after_pc", id_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
